// File: rtl/retire_trace_fifo_if.sv
// Retire-event input and trace-record output bundle for retire_trace_fifo.
// The master drives retire events and the sink's ready; the slave (FIFO) returns the head record.
interface retire_trace_fifo_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 32
) ();
  logic              ret_valid;
  logic [DATA_W-1:0] ret_pc;
  logic              ret_reg_write;
  logic [REG_W-1:0]  ret_write_reg;
  logic [DATA_W-1:0] ret_write_data;
  logic              ret_mem_read;
  logic              ret_mem_write;
  logic [DATA_W-1:0] ret_mem_addr;
  logic [DATA_W-1:0] ret_mem_data;
  logic              ret_halt;

  logic              rd_valid;
  logic              rd_ready;
  logic [CNT_W-1:0]  rd_inum;
  logic [CNT_W-1:0]  rd_cycle;
  logic [DATA_W-1:0] rd_pc;
  logic [2:0]        rd_kind;
  logic [REG_W-1:0]  rd_reg;
  logic [DATA_W-1:0] rd_wdata;
  logic [DATA_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_mdata;

  modport master (
    output ret_valid, ret_pc, ret_reg_write, ret_write_reg, ret_write_data,
           ret_mem_read, ret_mem_write, ret_mem_addr, ret_mem_data, ret_halt,
           rd_ready,
    input  rd_valid, rd_inum, rd_cycle, rd_pc, rd_kind, rd_reg, rd_wdata,
           rd_addr, rd_mdata
  );

  modport slave (
    input  ret_valid, ret_pc, ret_reg_write, ret_write_reg, ret_write_data,
           ret_mem_read, ret_mem_write, ret_mem_addr, ret_mem_data, ret_halt,
           rd_ready,
    output rd_valid, rd_inum, rd_cycle, rd_pc, rd_kind, rd_reg, rd_wdata,
           rd_addr, rd_mdata
  );
endinterface

// File: rtl/retire_trace_fifo.sv
// Retirement-trace capture: classifies writeback retire events, stamps them with
// instruction number and cycle count, and buffers them in a FIFO drained by valid/ready.
module retire_trace_fifo #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  retire_trace_fifo_if.slave       bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     halted,
  output logic                     done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [2:0] KIND_NOP   = 3'd0;
  localparam logic [2:0] KIND_REG   = 3'd1;
  localparam logic [2:0] KIND_LOAD  = 3'd2;
  localparam logic [2:0] KIND_STORE = 3'd3;
  localparam logic [2:0] KIND_STUPD = 3'd4;
  localparam logic [2:0] KIND_HALT  = 3'd5;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef struct packed {
    logic [CNT_W-1:0]  inum;
    logic [CNT_W-1:0]  cycle;
    logic [DATA_W-1:0] pc;
    logic [2:0]        kind;
    logic [REG_W-1:0]  rreg;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] mdata;
  } rec_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] inum_q, inum_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             overflow_q, overflow_d;
  logic             halted_q, halted_d;

  rec_t mem [DEPTH];
  rec_t rec_in;
  rec_t head;

  logic [2:0] kind;
  logic       use_reg;
  logic       use_addr;
  logic       use_mdata;
  logic       capture;
  logic       full;
  logic       pop;
  logic       push;
  logic       drop;

  // Classification priority: halt, store-update, load, reg write, store, nop/branch.
  always_comb begin
    kind = KIND_NOP;
    if (bus.ret_halt)
      kind = KIND_HALT;
    else if (bus.ret_reg_write && bus.ret_mem_write)
      kind = KIND_STUPD;
    else if (bus.ret_reg_write && bus.ret_mem_read)
      kind = KIND_LOAD;
    else if (bus.ret_reg_write)
      kind = KIND_REG;
    else if (bus.ret_mem_write)
      kind = KIND_STORE;

    use_reg   = (kind == KIND_REG) || (kind == KIND_LOAD) || (kind == KIND_STUPD);
    use_addr  = (kind == KIND_LOAD) || (kind == KIND_STORE) || (kind == KIND_STUPD);
    use_mdata = (kind == KIND_STORE) || (kind == KIND_STUPD);

    rec_in       = '0;
    rec_in.inum  = inum_q;
    rec_in.cycle = cycle_q;
    rec_in.pc    = bus.ret_pc;
    rec_in.kind  = kind;
    rec_in.rreg  = use_reg   ? bus.ret_write_reg  : '0;
    rec_in.wdata = use_reg   ? bus.ret_write_data : '0;
    rec_in.addr  = use_addr  ? bus.ret_mem_addr   : '0;
    rec_in.mdata = use_mdata ? bus.ret_mem_data   : '0;
  end

  // Popping frees a slot in the same cycle, so a full FIFO can still accept.
  always_comb begin
    full    = (count_q == OCC_FULL);
    pop     = (count_q != '0) && bus.rd_ready;
    capture = bus.ret_valid && !halted_q;
    push    = capture && (!full || pop);
    drop    = capture && full && !pop;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    inum_d       = inum_q;
    cycle_d      = cycle_q + CNT_ONE;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    halted_d     = halted_q;

    if (push)
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   count_d = count_q + OCC_ONE;
      2'b01:   count_d = count_q - OCC_ONE;
      default: count_d = count_q;
    endcase

    if (capture) begin
      inum_d = inum_q + CNT_ONE;
      if (bus.ret_halt)
        halted_d = 1'b1;
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1)
        drop_count_d = drop_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inum_q       <= '0;
      cycle_q      <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      inum_q       <= inum_d;
      cycle_q      <= cycle_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
      halted_q     <= halted_d;
    end
  end

  // Storage has no reset; entries are only observable once count covers them.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= rec_in;
  end

  assign head = mem[rd_ptr_q];

  assign bus.rd_valid = (count_q != '0);
  assign bus.rd_inum  = head.inum;
  assign bus.rd_cycle = head.cycle;
  assign bus.rd_pc    = head.pc;
  assign bus.rd_kind  = head.kind;
  assign bus.rd_reg   = head.rreg;
  assign bus.rd_wdata = head.wdata;
  assign bus.rd_addr  = head.addr;
  assign bus.rd_mdata = head.mdata;

  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign halted     = halted_q;
  assign done       = halted_q && (count_q == '0);

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Directed self-checking bench for retire_trace_fifo (DEPTH=16, DATA_W=16, CNT_W=32).
module tb_retire_trace_fifo;

  logic        clk;
  logic        rst;
  logic [4:0]  count;
  logic        overflow;
  logic [31:0] drop_count;
  logic        halted;
  logic        done;

  int total;
  int bad;

  retire_trace_fifo_if #(.DATA_W(16), .REG_W(3), .CNT_W(32)) bus ();

  retire_trace_fifo #(.DATA_W(16), .REG_W(3), .DEPTH(16), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count),
    .halted     (halted),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ret_valid      = 1'b0;
    bus.ret_pc         = '0;
    bus.ret_reg_write  = 1'b0;
    bus.ret_write_reg  = '0;
    bus.ret_write_data = '0;
    bus.ret_mem_read   = 1'b0;
    bus.ret_mem_write  = 1'b0;
    bus.ret_mem_addr   = '0;
    bus.ret_mem_data   = '0;
    bus.ret_halt       = 1'b0;
  endtask

  task automatic set_ret(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                         input logic [15:0] wd, input logic mr, input logic mw,
                         input logic [15:0] ma, input logic [15:0] md, input logic h);
    bus.ret_valid      = 1'b1;
    bus.ret_pc         = pc;
    bus.ret_reg_write  = rw;
    bus.ret_write_reg  = wr;
    bus.ret_write_data = wd;
    bus.ret_mem_read   = mr;
    bus.ret_mem_write  = mw;
    bus.ret_mem_addr   = ma;
    bus.ret_mem_data   = md;
    bus.ret_halt       = h;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.rd_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", bus.rd_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (drop_count !== 32'd0) begin bad++; $display("FAIL reset_drop_count got=%0d want=0", drop_count); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    $display("test_reset: state cleared");
  endtask

  task automatic test_basic();
    bus.rd_ready = 1'b1;
    // reg write with noise on memory fields
    set_ret(16'h0000, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'h5A5A, 16'h3C3C, 1'b0);
    step();
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL basic_valid0 got=%b want=1", bus.rd_valid); end
    total++; if (bus.rd_inum !== 32'd0) begin bad++; $display("FAIL basic_inum0 got=%0d want=0", bus.rd_inum); end
    total++; if (bus.rd_cycle !== 32'd0) begin bad++; $display("FAIL basic_cycle0 got=%0d want=0", bus.rd_cycle); end
    total++; if (bus.rd_kind !== 3'd1) begin bad++; $display("FAIL basic_kind0 got=%0d want=1", bus.rd_kind); end
    total++; if (bus.rd_reg !== 3'd3) begin bad++; $display("FAIL basic_reg0 got=%0d want=3", bus.rd_reg); end
    total++; if (bus.rd_wdata !== 16'h1234) begin bad++; $display("FAIL basic_wdata0 got=%h want=1234", bus.rd_wdata); end
    total++; if (bus.rd_addr !== 16'h0000) begin bad++; $display("FAIL basic_addr0 got=%h want=0000", bus.rd_addr); end
    total++; if (bus.rd_mdata !== 16'h0000) begin bad++; $display("FAIL basic_mdata0 got=%h want=0000", bus.rd_mdata); end
    $display("rec inum=%0d kind=%0d pc=%h", bus.rd_inum, bus.rd_kind, bus.rd_pc);
    set_ret(16'h0002, 1'b0, 3'd7, 16'hFFFF, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    step();
    total++; if (bus.rd_inum !== 32'd1) begin bad++; $display("FAIL basic_inum1 got=%0d want=1", bus.rd_inum); end
    total++; if (bus.rd_cycle !== 32'd1) begin bad++; $display("FAIL basic_cycle1 got=%0d want=1", bus.rd_cycle); end
    total++; if (bus.rd_kind !== 3'd3) begin bad++; $display("FAIL basic_kind1 got=%0d want=3", bus.rd_kind); end
    total++; if (bus.rd_pc !== 16'h0002) begin bad++; $display("FAIL basic_pc1 got=%h want=0002", bus.rd_pc); end
    total++; if (bus.rd_reg !== 3'd0) begin bad++; $display("FAIL basic_reg1 got=%0d want=0", bus.rd_reg); end
    total++; if (bus.rd_wdata !== 16'h0000) begin bad++; $display("FAIL basic_wdata1 got=%h want=0000", bus.rd_wdata); end
    total++; if (bus.rd_addr !== 16'h0010) begin bad++; $display("FAIL basic_addr1 got=%h want=0010", bus.rd_addr); end
    total++; if (bus.rd_mdata !== 16'hBEEF) begin bad++; $display("FAIL basic_mdata1 got=%h want=beef", bus.rd_mdata); end
    $display("rec inum=%0d kind=%0d pc=%h", bus.rd_inum, bus.rd_kind, bus.rd_pc);
    // halt wins over a simultaneous reg write
    set_ret(16'h0004, 1'b1, 3'd2, 16'h9999, 1'b0, 1'b0, 16'h7777, 16'h6666, 1'b1);
    step();
    idle();
    total++; if (bus.rd_inum !== 32'd2) begin bad++; $display("FAIL basic_inum2 got=%0d want=2", bus.rd_inum); end
    total++; if (bus.rd_cycle !== 32'd2) begin bad++; $display("FAIL basic_cycle2 got=%0d want=2", bus.rd_cycle); end
    total++; if (bus.rd_kind !== 3'd5) begin bad++; $display("FAIL basic_kind2 got=%0d want=5", bus.rd_kind); end
    total++; if (bus.rd_pc !== 16'h0004) begin bad++; $display("FAIL basic_pc2 got=%h want=0004", bus.rd_pc); end
    total++; if ({bus.rd_reg, bus.rd_wdata, bus.rd_addr, bus.rd_mdata} !== 51'd0) begin bad++; $display("FAIL basic_halt_fields got=%h want=0", {bus.rd_reg, bus.rd_wdata, bus.rd_addr, bus.rd_mdata}); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL basic_halted got=%b want=1", halted); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_early got=%b want=0", done); end
    $display("rec inum=%0d kind=%0d pc=%h", bus.rd_inum, bus.rd_kind, bus.rd_pc);
    step();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL basic_count_end got=%0d want=0", count); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", done); end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      set_ret(16'(2 * i), 1'b1, 3'(i), 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      step();
      if (i == 15) begin
        total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count_at_full got=%0d want=16", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_flag_at_full got=%b want=0", overflow); end
      end
    end
    idle();
    total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d want=16", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    total++; if (drop_count !== 32'd2) begin bad++; $display("FAIL ovf_drop_count got=%0d want=2", drop_count); end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.rd_inum !== 32'(i)) begin bad++; $display("FAIL ovf_drain_inum got=%0d want=%0d", bus.rd_inum, i); end
      total++; if (bus.rd_wdata !== 16'(i)) begin bad++; $display("FAIL ovf_drain_wdata got=%h want=%h", bus.rd_wdata, 16'(i)); end
      step();
    end
    bus.rd_ready = 1'b0;
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained_valid got=%b want=0", bus.rd_valid); end
    set_ret(16'h0100, 1'b1, 3'd1, 16'h0042, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    idle();
    total++; if (bus.rd_inum !== 32'd18) begin bad++; $display("FAIL ovf_refill_inum got=%0d want=18", bus.rd_inum); end
    total++; if (bus.rd_cycle !== 32'd34) begin bad++; $display("FAIL ovf_refill_cycle got=%0d want=34", bus.rd_cycle); end
    total++; if (bus.rd_wdata !== 16'h0042) begin bad++; $display("FAIL ovf_refill_wdata got=%h want=0042", bus.rd_wdata); end
    $display("test_overflow: refill rec inum=%0d", bus.rd_inum);
  endtask

  task automatic test_mid_reset();
    // continues from the overflow state: one record queued, overflow set
    for (int i = 0; i < 6; i++) begin
      set_ret(16'(16'h0200 + i), 1'b1, 3'd1, 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, (i == 5));
      step();
    end
    idle();
    total++; if (count !== 5'd7) begin bad++; $display("FAIL mrst_count_before got=%0d want=7", count); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL mrst_halted_before got=%b want=1", halted); end
    bus.rd_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.rd_ready = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL mrst_count got=%0d want=0", count); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL mrst_rd_valid got=%b want=0", bus.rd_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mrst_overflow got=%b want=0", overflow); end
    total++; if (drop_count !== 32'd0) begin bad++; $display("FAIL mrst_drop_count got=%0d want=0", drop_count); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL mrst_halted got=%b want=0", halted); end
    set_ret(16'h0ABC, 1'b1, 3'd2, 16'h5678, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    idle();
    total++; if (bus.rd_inum !== 32'd0) begin bad++; $display("FAIL mrst_inum got=%0d want=0", bus.rd_inum); end
    total++; if (bus.rd_cycle !== 32'd0) begin bad++; $display("FAIL mrst_cycle got=%0d want=0", bus.rd_cycle); end
    total++; if (bus.rd_pc !== 16'h0ABC) begin bad++; $display("FAIL mrst_pc got=%h want=0abc", bus.rd_pc); end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL mrst_count_after got=%0d want=1", count); end
    $display("test_mid_reset: rec inum=%0d cycle=%0d", bus.rd_inum, bus.rd_cycle);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_wd;
    do_reset();
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_ret(16'(i), 1'b1, 3'd4, 16'(16'h0100 + i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      step();
    end
    idle();
    total++; if (count !== 5'd16) begin bad++; $display("FAIL b2b_count_full got=%0d want=16", count); end
    for (int j = 0; j < 5; j++) begin
      set_ret(16'(16'h0040 + j), 1'b1, 3'd4, 16'(16'h0200 + j), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      bus.rd_ready = 1'b1;
      total++; if (bus.rd_wdata !== 16'(16'h0100 + j)) begin bad++; $display("FAIL b2b_head_wdata got=%h want=%h", bus.rd_wdata, 16'(16'h0100 + j)); end
      total++; if (bus.rd_inum !== 32'(j)) begin bad++; $display("FAIL b2b_head_inum got=%0d want=%0d", bus.rd_inum, j); end
      step();
      total++; if (count !== 5'd16) begin bad++; $display("FAIL b2b_count got=%0d want=16", count); end
    end
    idle();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow got=%b want=0", overflow); end
    total++; if (drop_count !== 32'd0) begin bad++; $display("FAIL b2b_drop_count got=%0d want=0", drop_count); end
    for (int k = 0; k < 16; k++) begin
      exp_wd = (k < 11) ? 16'(16'h0105 + k) : 16'(16'h0200 + k - 11);
      total++; if (bus.rd_wdata !== exp_wd) begin bad++; $display("FAIL b2b_drain_wdata got=%h want=%h", bus.rd_wdata, exp_wd); end
      total++; if (bus.rd_inum !== 32'(5 + k)) begin bad++; $display("FAIL b2b_drain_inum got=%0d want=%0d", bus.rd_inum, 5 + k); end
      step();
    end
    bus.rd_ready = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL b2b_count_end got=%0d want=0", count); end
    $display("test_back_to_back: 21 records in order");
  endtask

  task automatic test_kinds();
    do_reset();
    bus.rd_ready = 1'b0;
    set_ret(16'h0010, 1'b1, 3'd5, 16'h00AA, 1'b1, 1'b0, 16'h0100, 16'h5555, 1'b0);
    step();
    set_ret(16'h0012, 1'b1, 3'd6, 16'h0077, 1'b0, 1'b1, 16'h0200, 16'h1111, 1'b0);
    step();
    set_ret(16'h0014, 1'b0, 3'd4, 16'h4444, 1'b1, 1'b0, 16'h0300, 16'h2222, 1'b0);
    step();
    idle();
    total++; if (bus.rd_kind !== 3'd2) begin bad++; $display("FAIL kind_load got=%0d want=2", bus.rd_kind); end
    total++; if ({bus.rd_reg, bus.rd_wdata, bus.rd_addr, bus.rd_mdata} !== {3'd5, 16'h00AA, 16'h0100, 16'h0000}) begin bad++; $display("FAIL kind_load_fields got=%h want=%h", {bus.rd_reg, bus.rd_wdata, bus.rd_addr, bus.rd_mdata}, {3'd5, 16'h00AA, 16'h0100, 16'h0000}); end
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
    total++; if (bus.rd_kind !== 3'd4) begin bad++; $display("FAIL kind_stupd got=%0d want=4", bus.rd_kind); end
    total++; if ({bus.rd_reg, bus.rd_wdata, bus.rd_addr, bus.rd_mdata} !== {3'd6, 16'h0077, 16'h0200, 16'h1111}) begin bad++; $display("FAIL kind_stupd_fields got=%h want=%h", {bus.rd_reg, bus.rd_wdata, bus.rd_addr, bus.rd_mdata}, {3'd6, 16'h0077, 16'h0200, 16'h1111}); end
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
    total++; if (bus.rd_kind !== 3'd0) begin bad++; $display("FAIL kind_nop got=%0d want=0", bus.rd_kind); end
    total++; if ({bus.rd_reg, bus.rd_wdata, bus.rd_addr, bus.rd_mdata} !== 51'd0) begin bad++; $display("FAIL kind_nop_fields got=%h want=0", {bus.rd_reg, bus.rd_wdata, bus.rd_addr, bus.rd_mdata}); end
    total++; if (bus.rd_pc !== 16'h0014) begin bad++; $display("FAIL kind_nop_pc got=%h want=0014", bus.rd_pc); end
    $display("test_kinds: load/store-update/nop checked");
  endtask

  task automatic test_after_halt();
    do_reset();
    bus.rd_ready = 1'b0;
    set_ret(16'h0020, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      set_ret(16'(16'h0022 + 2 * i), 1'b1, 3'd1, 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      step();
    end
    idle();
    total++; if (count !== 5'd1) begin bad++; $display("FAIL halt_count got=%0d want=1", count); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_halted got=%b want=1", halted); end
    total++; if (drop_count !== 32'd0) begin bad++; $display("FAIL halt_drop_count got=%0d want=0", drop_count); end
    total++; if (bus.rd_kind !== 3'd5) begin bad++; $display("FAIL halt_kind got=%0d want=5", bus.rd_kind); end
    total++; if (bus.rd_inum !== 32'd0) begin bad++; $display("FAIL halt_inum got=%0d want=0", bus.rd_inum); end
    bus.rd_ready = 1'b1;
    step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL halt_done got=%b want=1", done); end
    set_ret(16'h0030, 1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    idle();
    bus.rd_ready = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL halt_ignored_count got=%0d want=0", count); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL halt_ignored_valid got=%b want=0", bus.rd_valid); end
    $display("test_after_halt: post-halt retires ignored");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_mid_reset();
    test_back_to_back();
    test_kinds();
    test_after_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/retire_trace_fifo.md
Name: retire_trace_fifo

Overview:
- Synthesizable retirement-trace capture block that replaces the simulation-only trace monitor for the pipelined processor.
- It samples one retire event per cycle from the writeback stage and classifies it (NOP/branch, reg write, load, store, store-update, halt).
- Each event is stamped with an instruction number and a cycle count, then buffered in a parametrised FIFO.
- Records drain through a valid/ready port to a trace sink (bench reader or debug UART).

Parameters:
DATA_W, 16, width of PC, write data, memory address and memory data
REG_W, 3, register specifier width
DEPTH, 16, FIFO entries; must be a power of two, at least 2
CNT_W, 32, width of the instruction and cycle counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ret_valid  in  1  a retire event is presented this cycle
ret_pc  in  DATA_W  PC of the retiring instruction
ret_reg_write  in  1  register file written
ret_write_reg  in  REG_W  destination register
ret_write_data  in  DATA_W  register write data
ret_mem_read  in  1  memory read performed
ret_mem_write  in  1  memory write performed
ret_mem_addr  in  DATA_W  memory address
ret_mem_data  in  DATA_W  memory store data
ret_halt  in  1  halt retiring
rd_valid  out  1  head record available
rd_ready  in  1  sink accepts the head record
rd_inum  out  CNT_W  instruction number of the head record
rd_cycle  out  CNT_W  cycle stamp of the head record
rd_pc  out  DATA_W  head PC
rd_kind  out  3  0 nop/branch, 1 reg, 2 load, 3 store, 4 store-update, 5 halt
rd_reg  out  REG_W  head destination register (0 when unused)
rd_wdata  out  DATA_W  head register data (0 when unused)
rd_addr  out  DATA_W  head memory address (0 when unused)
rd_mdata  out  DATA_W  head store data (0 when unused)
count  out  log2(DEPTH)+1  current occupancy
overflow  out  1  sticky: at least one record was dropped
drop_count  out  CNT_W  number of dropped records
halted  out  1  halt record accepted; capture is frozen
done  out  1  halted and FIFO empty

Behaviour:
- Reset (synchronous, rst=1 at posedge): pointers, count, inum, cycle, drop_count, overflow, halted and done all clear to 0. rd_valid=0. Record storage contents are don't-care. rst has priority over all other events.
- Cycle counter: increments every non-reset cycle and wraps modulo 2^CNT_W. An accepted record stores the counter value from its sample cycle, so the first cycle after reset stamps 0.
- Kind classification, evaluated in this priority order:
  - ret_halt gives 5.
  - ret_reg_write & ret_mem_write gives 4.
  - ret_reg_write & ret_mem_read gives 2.
  - ret_reg_write gives 1.
  - ret_mem_write gives 3.
  - Otherwise 0.
- Unused fields are forced to 0:
  - reg and wdata are zeroed for kinds 0, 3 and 5.
  - addr is zeroed for kinds 0, 1 and 5.
  - mdata is zeroed for every kind except 3 and 4.
- Instruction number:
  - Every ret_valid sampled while halted=0 consumes the current inum and then increments it, even if the record is dropped.
  - The first event gets inum 0, so a gap in rd_inum identifies drops.
- Push condition: ret_valid & ~halted & (count<DEPTH | pop), where pop = rd_valid & rd_ready.
  - A simultaneous push and pop at full is legal; count stays at DEPTH.
- Drop: ret_valid & ~halted & count==DEPTH & ~pop.
  - Sets overflow and increments drop_count, which saturates at all-ones.
  - inum still increments.
  - A dropped halt still sets halted.
- Pop: rd_valid & rd_ready advances the read pointer.
  - rd_* present the head entry combinationally from storage; rd_valid = (count!=0).
  - rd_* hold stable while rd_valid=1 and rd_ready=0.
  - rd_ready while empty has no effect.
- Latency: a record pushed in cycle N is visible on rd_valid in cycle N+1 at the earliest. There is no bypass.
- Pointers are log2(DEPTH) bits wide and wrap naturally. count is updated +1, -1 or 0 per cycle.
- Halt:
  - Accepting or dropping a kind-5 event sets halted the next cycle.
  - While halted, all ret_valid inputs are ignored: no push, no inum change, no drop.
  - The cycle counter keeps running.
  - done = halted & (count==0).
  - Only rst clears halted.
- Reset mid-operation empties the FIFO immediately. A record being popped in the reset cycle is lost, and the sink must not count it.
- ret_valid=0 cycles produce no record and do not change inum.

Test Plan:
- Reset then 3 retires (reg write r3=0x1234 at PC 0x0000, store addr 0x0010 data 0xBEEF at PC 0x0002, halt at PC 0x0004), rd_ready=1 -> records inum 0/1/2, kinds 1/3/5, cycle stamps 0/1/2, halted=1, then done=1.
- rd_ready=0 with DEPTH=16 and 18 consecutive reg-write retires -> count=16, overflow=1, drop_count=2. Draining yields inum 0..15, and the next record after refill shows inum 18.
- Full FIFO with push and pop in the same cycle for 5 cycles -> count stays 16, no drops, and record order is preserved across pointer wrap.
- Load (reg_write, mem_read, r5=0x00AA, addr 0x0100) and store-update (reg_write, mem_write) -> kinds 2 and 4. Load mdata=0, and store-update carries reg, wdata, addr and mdata.
- Retires after an accepted halt (3 more ret_valid) -> no new records, inum unchanged, drop_count unchanged.
- rst asserted with count=7 -> next cycle count=0, rd_valid=0, overflow=0, halted=0, and the next retire gets inum 0 and cycle stamp 0.
